// File: rtl/ps_pkg.sv
// Shared AXI response codes and FSM state encodings
// for the PS general-purpose register bank.
package ps_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wr_state_t;
    typedef enum logic { R_IDLE, R_DATA } rd_state_t;

endpackage

// File: rtl/ps_gp_regfile.sv
// Register array with byte-strobe merge, per-register write pulse
// and the RO-aware read mux.
module ps_gp_regfile
    import ps_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter int                  IDXW     = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         i_we,
    input  logic [IDXW-1:0]              i_widx,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [DATA_W/8-1:0]          i_wstrb,
    input  logic [IDXW-1:0]              i_ridx,
    input  logic [NUM_REGS*DATA_W-1:0]   i_reg_in,
    output logic [DATA_W-1:0]            o_rdata,
    output logic [NUM_REGS*DATA_W-1:0]   o_reg_out,
    output logic [NUM_REGS-1:0]          o_wr_pulse
);

    localparam int SW = DATA_W / 8;

    logic [NUM_REGS-1:0] r_pulse;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign o_reg_out[g*DATA_W +: DATA_W] = '0;
        end else begin : g_rw
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    r_q <= '0;
                end else if (i_we && (i_widx == IDXW'(g))) begin
                    for (int b = 0; b < SW; b++) begin
                        if (i_wstrb[b]) begin
                            r_q[b*8 +: 8] <= i_wdata[b*8 +: 8];
                        end
                    end
                end
            end
            assign o_reg_out[g*DATA_W +: DATA_W] = r_q;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= '0;
            if (i_we) begin
                r_pulse[i_widx] <= 1'b1;
            end
        end
    end

    assign o_wr_pulse = r_pulse;

    // RO slots show live status from the PL side instead of the store.
    always_comb begin
        o_rdata = o_reg_out[int'(i_ridx)*DATA_W +: DATA_W];
        if (RO_MASK[i_ridx]) begin
            o_rdata = i_reg_in[int'(i_ridx)*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/ps_gp_regbank.sv
// AXI4-Lite slave front end for the PS general-purpose register bank:
// independent write and read FSMs around ps_gp_regfile.
module ps_gp_regbank #(
    parameter int                  DATA_W   = 32,
    parameter int                  NUM_REGS = 16,
    parameter int                  ADDR_W   = 12,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [ADDR_W-1:0]           s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_W-1:0]           s_axi_wdata,
    input  logic [DATA_W/8-1:0]         s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [ADDR_W-1:0]           s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_W-1:0]           s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]  reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]  reg_in,
    output logic [NUM_REGS-1:0]         wr_pulse
);

    import ps_pkg::*;

    localparam int LSB  = $clog2(DATA_W / 8);
    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    wr_state_t r_wst, w_wst_nxt;
    rd_state_t r_rst, w_rst_nxt;

    logic                r_live;
    logic                r_aw_done;
    logic                r_w_done;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic [1:0]          r_bresp;
    logic [1:0]          r_rresp;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_aw_hs, w_w_hs, w_b_hs;
    logic                w_ar_hs, w_r_hs;
    logic                w_commit, w_we;
    logic [ADDR_W-1:0]   w_aw_word, w_ar_word;
    logic [IDXW-1:0]     w_aw_idx, w_ar_idx;
    logic                w_aw_ok, w_ar_ok;
    logic [DATA_W-1:0]   w_rf_rdata;

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid & s_axi_wready;
    assign w_b_hs  = s_axi_bvalid & s_axi_bready;
    assign w_ar_hs = s_axi_arvalid & s_axi_arready;
    assign w_r_hs  = s_axi_rvalid & s_axi_rready;

    // Word address: index bits plus anything above must be zero.
    assign w_aw_word = r_awaddr >> LSB;
    assign w_aw_idx  = w_aw_word[IDXW-1:0];
    assign w_aw_ok   = ((w_aw_word >> IDXW) == '0)
                    && (int'(w_aw_idx) < NUM_REGS);

    assign w_ar_word = s_axi_araddr >> LSB;
    assign w_ar_idx  = w_ar_word[IDXW-1:0];
    assign w_ar_ok   = ((w_ar_word >> IDXW) == '0)
                    && (int'(w_ar_idx) < NUM_REGS);

    assign w_commit = (r_wst == W_IDLE) & r_aw_done & r_w_done;
    assign w_we     = w_commit & w_aw_ok & ~RO_MASK[w_aw_idx];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_commit) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
                r_awaddr  <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wst <= W_IDLE;
        end else begin
            r_wst <= w_wst_nxt;
        end
    end

    always_comb begin
        w_wst_nxt = r_wst;
        unique case (r_wst)
            W_IDLE: if (w_commit) w_wst_nxt = W_RESP;
            W_RESP: if (w_b_hs) w_wst_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        unique case (r_wst)
            W_IDLE: begin
                s_axi_awready = r_live & ~r_aw_done;
                s_axi_wready  = r_live & ~r_w_done;
            end
            W_RESP: s_axi_bvalid = 1'b1;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bresp <= RESP_OKAY;
        end else if (w_commit) begin
            r_bresp <= w_aw_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst <= R_IDLE;
        end else begin
            r_rst <= w_rst_nxt;
        end
    end

    always_comb begin
        w_rst_nxt = r_rst;
        unique case (r_rst)
            R_IDLE: if (w_ar_hs) w_rst_nxt = R_DATA;
            R_DATA: if (w_r_hs) w_rst_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        unique case (r_rst)
            R_IDLE: s_axi_arready = r_live;
            R_DATA: s_axi_rvalid  = 1'b1;
        endcase
    end

    // Sampled before a same-edge commit lands, so reads see the old value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= w_ar_ok ? w_rf_rdata : '0;
            r_rresp <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi_bresp = r_bresp;
    assign s_axi_rdata = r_rdata;
    assign s_axi_rresp = r_rresp;

    ps_gp_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDXW     (IDXW),
        .RO_MASK  (RO_MASK)
    ) u_regfile (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .i_we       (w_we),
        .i_widx     (w_aw_idx),
        .i_wdata    (r_wdata),
        .i_wstrb    (r_wstrb),
        .i_ridx     (w_ar_idx),
        .i_reg_in   (reg_in),
        .o_rdata    (w_rf_rdata),
        .o_reg_out  (reg_out),
        .o_wr_pulse (wr_pulse)
    );

endmodule

// File: doc/ps_gp_regbank.md
PS_GP_REGBANK -- requirements
Module: ps_gp_regbank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning AXI4-Lite data width (32 or 64).
REQ-002 The block SHALL have parameter NUM_REGS, default 16, meaning register count (1..256).
REQ-003 The block SHALL have parameter ADDR_W, default 12, meaning AXI byte-address width.
REQ-004 The block SHALL have parameter RO_MASK, default all-zero, NUM_REGS bits, meaning bit i=1 makes register i read-only (reads reg_in[i]).
REQ-005 The block SHALL have a port aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have a port aresetn, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have ports s_axi_awaddr in ADDR_W, s_axi_awvalid in 1, s_axi_awready out 1, meaning the write-address channel.
REQ-008 The block SHALL have ports s_axi_wdata in DATA_W, s_axi_wstrb in DATA_W/8, s_axi_wvalid in 1, s_axi_wready out 1, meaning the write-data channel.
REQ-009 The block SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1, meaning the write-response channel.
REQ-010 The block SHALL have ports s_axi_araddr in ADDR_W, s_axi_arvalid in 1, s_axi_arready out 1, meaning the read-address channel.
REQ-011 The block SHALL have ports s_axi_rdata out DATA_W, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1, meaning the read-data channel.
REQ-012 The block SHALL have ports reg_out out NUM_REGS*DATA_W, reg_in in NUM_REGS*DATA_W, wr_pulse out NUM_REGS, meaning control values to PL, status values from PL, and per-register write strobes.

Function
REQ-013 Register index SHALL be addr[log2(DATA_W/8) +: log2(NUM_REGS)]; the low byte-offset bits SHALL be ignored.
REQ-014 An address with index >= NUM_REGS or any higher address bit set SHALL be out of range.
REQ-015 The write FSM SHALL have states W_IDLE, W_RESP; in W_IDLE, awready and wready SHALL each be 1 until their channel is latched.
REQ-016 AW and W SHALL be accepted independently, in either order or in the same cycle, each latched once.
REQ-017 The cycle after both are latched, the write SHALL commit, bvalid SHALL rise, and the FSM SHALL enter W_RESP with awready=wready=0.
REQ-018 A commit SHALL update only the bytes of the register whose wstrb bit is 1 and SHALL pulse wr_pulse[idx] high for exactly one cycle.
REQ-019 An in-range commit SHALL give bresp=OKAY (00); a commit to a RO register SHALL change nothing, give no pulse and give OKAY.
REQ-020 An out-of-range commit SHALL change nothing, give no pulse and give bresp=SLVERR (10).
REQ-021 bvalid SHALL hold with stable bresp until bvalid&&bready, then return to W_IDLE the next cycle.
REQ-022 The read FSM SHALL have states R_IDLE, R_DATA; in R_IDLE arready SHALL be 1.
REQ-023 On arvalid&&arready, rdata and rresp SHALL be registered and rvalid SHALL rise the next cycle, with arready=0 in R_DATA.
REQ-024 rdata SHALL be reg_in[idx] for RO registers and the stored value otherwise; out-of-range reads SHALL return 0 with SLVERR.
REQ-025 rvalid and rdata SHALL hold until rvalid&&rready, then return to R_IDLE.
REQ-026 The read and write paths SHALL be independent; a read accepted in the cycle of a commit to the same register SHALL return the pre-commit value.
REQ-027 reg_out SHALL be the stored register values driven directly from flops; RO slices SHALL be 0.

Reset
REQ-028 While aresetn=0, all stored registers, reg_out, wr_pulse, bvalid, rvalid, rdata, bresp and rresp SHALL be 0, awready/wready/arready SHALL be 0, and both FSMs SHALL be idle.
REQ-029 Ready outputs SHALL rise on the first aclk edge after aresetn deasserts.
REQ-030 Reset mid-transaction SHALL discard latched AW/W/AR without any commit.

Structure
REQ-031 Package ps_pkg SHALL hold the RESP_OKAY/RESP_SLVERR constants and the wr_state_t and rd_state_t enums.
REQ-032 The register array and its strobe-merge logic SHALL live in the single sub-module ps_gp_regfile; the AXI FSMs stay in the top.

Verification
REQ-033 AW and W in the same cycle, addr 0x008, data 0xDEADBEEF, wstrb 1111 -> reg_out[2]=0xDEADBEEF and bvalid=1 the next cycle, bresp=00, wr_pulse[2] one cycle.
REQ-034 W three cycles before AW, addr 0x004, wstrb 0010, data 0x0000AB00, over prior 0x11223344 -> reg 1 = 0x1122AB44.
REQ-035 Write to addr 0x040 with NUM_REGS=16 -> bresp=10, no reg_out change, no wr_pulse.
REQ-036 RO_MASK bit 3 set, reg_in[3]=0x5A5A5A5A, read 0x00C -> rdata=0x5A5A5A5A, rresp=00; write to 0x00C -> no change, OKAY.
REQ-037 bready and rready held low 10 cycles -> bvalid/rvalid and payload stable, no new AW/W/AR accepted.
REQ-038 aresetn pulled low while bvalid=1 -> bvalid=0 and reg_out=0 immediately, ready outputs 1 one edge after release.
